// File: rtl/fma16_result_stage.sv
// fma16_result_stage
//   Output stage of the half-precision FMA unit. Each accepted {result, flags}
//   pair is written into an in-order FIFO with valid/ready handshakes on both
//   sides, and the flags of every accepted pair are OR-ed into sticky_flags.
//
//   Build option: FMA16_NAN_CANON_EN
//     defined   - NaN results are stored as canonical quiet NaN 16'h7E00
//     undefined - results are stored bit-exact
//
//   Ports
//     clk           in   clock, rising edge
//     reset         in   asynchronous active-high reset
//     in_valid      in   upstream pair valid
//     in_ready      out  stage can accept a pair (never depends on out_ready)
//     in_result     in   fp16 result
//     in_flags      in   {NV, OF, UF, NX}
//     out_valid     out  head entry available
//     out_ready     in   consumer accepts head entry
//     out_result    out  head result (0 when empty)
//     out_flags     out  head flags (0 when empty)
//     sticky_flags  out  OR of flags of accepted pairs since last clear
//     sticky_clr    in   clear sticky_flags
//     count         out  occupied entries, 0..DEPTH
//
//   Occupancy (decoded from count)
//     state        | meaning
//     OCC_EMPTY    | no entries, out_valid low
//     OCC_PARTIAL  | 1..DEPTH-1 entries, push and pop both possible
//     OCC_FULL     | DEPTH entries, in_ready low
module fma16_result_stage #(
    parameter int DEPTH = 4,                  // power of 2, >= 2
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_result,
    input  logic [3:0]    in_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_result,
    output logic [3:0]    out_flags,
    output logic [3:0]    sticky_flags,
    input  logic          sticky_clr,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    logic [15:0]   mem_result [DEPTH];
    logic [3:0]    mem_flags  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    occ;
    logic          push;
    logic          pop;
    logic [15:0]   store_result;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == CW'(DEPTH))
            occ = OCC_FULL;
    end

    // No pass-through when full: a pop in the same cycle does not free a slot
    // until the next edge, which keeps in_ready a pure function of state.
    assign in_ready   = ~reset & (occ != OCC_FULL);
    assign out_valid  = (occ != OCC_EMPTY);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_result = out_valid ? mem_result[rd_ptr] : 16'h0000;
    assign out_flags  = out_valid ? mem_flags[rd_ptr]  : 4'h0;

`ifdef FMA16_NAN_CANON_EN
    always_comb begin
        store_result = in_result;
        if (in_result[14:10] == 5'h1F && in_result[9:0] != 10'h000)
            store_result = 16'h7E00;
    end
`else
    assign store_result = in_result;
`endif

    // Storage is not reset; out_valid gates stale contents after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= store_result;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    // Pointers are AW bits wide so DEPTH-1 wraps to 0 without extra logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sticky_flags <= 4'h0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A clear in the same cycle as a push keeps the pushed flags.
            sticky_flags <= (sticky_clr ? 4'h0 : sticky_flags) | (push ? in_flags : 4'h0);
        end
    end

endmodule

// File: tb/tb_fma16_result_stage.sv
module tb_fma16_result_stage;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_result = 16'h0;
    logic [3:0]    in_flags = 4'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_result;
    logic [3:0]    out_flags;
    logic [3:0]    sticky_flags;
    logic          sticky_clr = 1'b0;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {result, flags} plus a sticky accumulator.
    logic [19:0] mq[$];
    logic [3:0]  msticky = 4'h0;

    fma16_result_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] canon(input logic [15:0] r);
`ifdef FMA16_NAN_CANON_EN
        // Any magnitude above +Inf is a NaN.
        if ((r & 16'h7FFF) > 16'h7C00) return 16'h7E00;
`endif
        return r;
    endfunction

    // {in_ready, out_valid, out_result, out_flags, count, sticky_flags}
    function automatic logic [28:0] got_vec();
        return {in_ready, out_valid, out_result, out_flags, count, sticky_flags};
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [19:0] h;
        int n;
        n = mq.size();
        h = (n != 0) ? mq[0] : 20'h0;
        return {(!reset && n != DEPTH), (n != 0), h, 3'(n), msticky};
    endfunction

    // Advance one clock and update the model from the inputs held over it.
    task automatic tick();
        bit p, q;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            msticky = 4'h0;
        end else begin
            p = in_valid && (mq.size() < DEPTH);
            q = out_ready && (mq.size() != 0);
            msticky = (sticky_clr ? 4'h0 : msticky) | (p ? in_flags : 4'h0);
            if (q) void'(mq.pop_front());
            if (p) mq.push_back({canon(in_result), in_flags});
        end
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (got_vec() !== {1'b0, 28'h0}) begin
            errors++; $display("FAIL reset_async got=%h exp=%h", got_vec(), {1'b0, 28'h0});
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (got_vec() !== {1'b1, 28'h0}) begin
            errors++; $display("FAIL reset_idle got=%h exp=%h", got_vec(), {1'b1, 28'h0});
        end
    endtask

    task automatic test_single();
        out_ready = 1'b0; in_valid = 1'b1; in_result = 16'h3C00; in_flags = 4'h0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h3C00 || count !== 3'd1) begin
            errors++; $display("FAIL single_push got=%b/%h/%0d exp=1/3c00/1", out_valid, out_result, count);
        end
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL single_model got=%h exp=%h", got_vec(), exp_vec());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (got_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_full();
        logic [15:0] vals [5];
        vals = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
        out_ready = 1'b0; in_flags = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_result = vals[i];
            tick();
        end
        in_result = vals[4];
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_count got=%0d/%b exp=4/0", count, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec() || count !== 3'd4) begin
                errors++; $display("FAIL full_hold got=%h exp=%h", got_vec(), exp_vec());
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_result !== 16'h4200 || count !== 3'd3) begin
            errors++; $display("FAIL full_pop got=%b/%h/%0d exp=1/4200/3", in_ready, out_result, count);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (got_vec() !== exp_vec() || count !== 3'd4) begin
            errors++; $display("FAIL full_refill got=%h exp=%h", got_vec(), exp_vec());
        end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== vals[i]) begin
                errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_result, vals[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (got_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_empty got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_sticky();
        sticky_clr = 1'b1; in_valid = 1'b0;
        tick();
        sticky_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_result = 16'h1234;
        in_flags = 4'b0001;
        tick();
        in_flags = 4'b1000;
        tick();
        checks++;
        if (sticky_flags !== 4'b1001 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL sticky_or got=%b exp=1001", sticky_flags);
        end
        sticky_clr = 1'b1; in_flags = 4'b0100;
        tick();
        sticky_clr = 1'b0; in_valid = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0100 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL sticky_clr_push got=%b exp=0100", sticky_flags);
        end
        in_flags = 4'b0010;
        tick();
        out_ready = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0100 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL sticky_hold got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_flags = 4'h0;
        for (int i = 0; i < 2; i++) begin
            in_result = 16'(16'h5000 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 16'($urandom_range(0, 16'h7BFF));
            tick();
            checks++;
            if (got_vec() !== exp_vec() || count !== 3'd2) begin
                errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        checks++;
        if (got_vec() !== exp_vec() || count !== 3'd0) begin
            errors++; $display("FAIL b2b_drain got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_nan();
        logic [15:0] want;
`ifdef FMA16_NAN_CANON_EN
        want = 16'h7E00;
`else
        want = 16'hFE01;
`endif
        out_ready = 1'b0; in_valid = 1'b1; in_result = 16'hFE01; in_flags = 4'b1000;
        tick();
        in_result = 16'hFC00; in_flags = 4'h0; out_ready = 1'b1;
        checks++;
        if (out_result !== want || out_flags !== 4'b1000) begin
            errors++; $display("FAIL nan_store got=%h/%b exp=%h/1000", out_result, out_flags, want);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 16'hFC00 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL nan_inf got=%h exp=fc00", out_result);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) == 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            in_flags   = 4'($urandom);
            in_result  = ($urandom_range(0, 5) == 0) ? 16'($urandom | 32'h7C00) : 16'($urandom);
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        in_valid = 1'b0; sticky_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_flags = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            in_result = 16'(16'h6000 + i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL mid_fill got=%h exp=%h", got_vec(), exp_vec());
        end
        #2 reset = 1'b1;
        mq.delete();
        msticky = 4'h0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || sticky_flags !== 4'h0 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL mid_reset got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (got_vec() !== exp_vec() || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_sticky();
        test_back_to_back();
        test_nan();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
